// File: rtl/subbytes_sched_if.sv
// Handshake and result bus between the SubBytes scheduler and its two requesters.
// The round datapath uses the st_* group and key expansion uses the kw_* group.
interface subbytes_sched_if;
   logic         st_valid;
   logic         st_ready;
   logic [127:0] st_data;
   logic         st_out_valid;
   logic [127:0] st_out;
   logic         kw_valid;
   logic         kw_ready;
   logic [31:0]  kw_data;
   logic         kw_out_valid;
   logic [31:0]  kw_out;
   logic         busy;

   modport master (
      output st_valid, st_data, kw_valid, kw_data,
      input  st_ready, st_out_valid, st_out, kw_ready, kw_out_valid, kw_out, busy
   );

   modport slave (
      input  st_valid, st_data, kw_valid, kw_data,
      output st_ready, st_out_valid, st_out, kw_ready, kw_out_valid, kw_out, busy
   );
endinterface

// File: rtl/subbytes_sched.sv
// Time-multiplexed SubBytes: one 32-bit S-box bank shared between a 128-bit state job
// (four words, one per cycle) and 32-bit SubWord requests from key expansion.
module subbytes_sched #(
   parameter int MAX_KEY_STEAL = 1
) (
   input logic              clk,
   input logic              rst_n,
   subbytes_sched_if.slave  bus
);

   localparam int SW = (MAX_KEY_STEAL < 1) ? 1 : $clog2(MAX_KEY_STEAL + 1);
   localparam logic [SW-1:0] STEAL_MAX = SW'(MAX_KEY_STEAL);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0), then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = gf_mul(a, a);
      inv = sq;
      for (int k = 2; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   logic [0:3][31:0] st_buf_q, st_buf_d;
   logic [0:2][31:0] st_acc_q, st_acc_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             st_active_q, st_active_d;
   logic [31:0]      kw_buf_q, kw_buf_d;
   logic             kw_pend_q, kw_pend_d;
   logic [SW-1:0]    steal_q, steal_d;
   logic [127:0]     st_out_q, st_out_d;
   logic             st_out_valid_q, st_out_valid_d;
   logic [31:0]      kw_out_q, kw_out_d;
   logic             kw_out_valid_q, kw_out_valid_d;

   logic        st_ready_w, kw_ready_w;
   logic        steal_ok, key_gnt, st_gnt;
   logic [31:0] bank_in, bank_out;

   generate
      if (MAX_KEY_STEAL == 0) begin : g_no_steal
         assign steal_ok = 1'b0;
      end else begin : g_steal
         assign steal_ok = (steal_q < STEAL_MAX);
      end
   endgenerate

   assign key_gnt = kw_pend_q && (!st_active_q || steal_ok);
   assign st_gnt  = !key_gnt && st_active_q;
   assign bank_in = key_gnt ? kw_buf_q : (st_gnt ? st_buf_q[cnt_q] : 32'h0);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign bank_out[8*gi +: 8] = sbox(bank_in[8*gi +: 8]);
      end
   endgenerate

   assign st_ready_w = rst_n && !st_active_q;
   assign kw_ready_w = rst_n && !kw_pend_q;

   always_comb begin
      st_buf_d       = st_buf_q;
      st_acc_d       = st_acc_q;
      cnt_d          = cnt_q;
      st_active_d    = st_active_q;
      kw_buf_d       = kw_buf_q;
      kw_pend_d      = kw_pend_q;
      steal_d        = steal_q;
      st_out_d       = st_out_q;
      st_out_valid_d = 1'b0;
      kw_out_d       = kw_out_q;
      kw_out_valid_d = 1'b0;

      if (key_gnt) begin
         kw_out_d       = bank_out;
         kw_out_valid_d = 1'b1;
         kw_pend_d      = 1'b0;
         if (st_active_q && (steal_q != STEAL_MAX)) steal_d = steal_q + 1'b1;
      end else if (st_gnt) begin
         steal_d = '0;
         cnt_d   = cnt_q + 2'd1;
         case (cnt_q)
            2'd0: st_acc_d[0] = bank_out;
            2'd1: st_acc_d[1] = bank_out;
            2'd2: st_acc_d[2] = bank_out;
            default: begin
               st_out_d       = {st_acc_q, bank_out};
               st_out_valid_d = 1'b1;
               st_active_d    = 1'b0;
            end
         endcase
      end

      // Accepts never collide with grants: each needs its own pending flag in the opposite state.
      if (bus.st_valid && st_ready_w) begin
         st_buf_d    = bus.st_data;
         cnt_d       = 2'd0;
         st_active_d = 1'b1;
      end
      if (bus.kw_valid && kw_ready_w) begin
         kw_buf_d  = bus.kw_data;
         kw_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_buf_q       <= '0;
         st_acc_q       <= '0;
         cnt_q          <= '0;
         st_active_q    <= 1'b0;
         kw_buf_q       <= '0;
         kw_pend_q      <= 1'b0;
         steal_q        <= '0;
         st_out_q       <= '0;
         st_out_valid_q <= 1'b0;
         kw_out_q       <= '0;
         kw_out_valid_q <= 1'b0;
      end else begin
         st_buf_q       <= st_buf_d;
         st_acc_q       <= st_acc_d;
         cnt_q          <= cnt_d;
         st_active_q    <= st_active_d;
         kw_buf_q       <= kw_buf_d;
         kw_pend_q      <= kw_pend_d;
         steal_q        <= steal_d;
         st_out_q       <= st_out_d;
         st_out_valid_q <= st_out_valid_d;
         kw_out_q       <= kw_out_d;
         kw_out_valid_q <= kw_out_valid_d;
      end
   end

   assign bus.st_ready     = st_ready_w;
   assign bus.kw_ready     = kw_ready_w;
   assign bus.st_out       = st_out_q;
   assign bus.st_out_valid = st_out_valid_q;
   assign bus.kw_out       = kw_out_q;
   assign bus.kw_out_valid = kw_out_valid_q;
   assign bus.busy         = rst_n && (st_active_q || kw_pend_q || st_out_valid_q || kw_out_valid_q);

endmodule

// File: tb/tb_subbytes_sched.sv
// Bench for subbytes_sched: directed latency/ordering cases plus random traffic checked
// against a table-based S-box model and a job scoreboard.
module tb_subbytes_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   subbytes_sched_if u_if ();
   subbytes_sched_if z_if ();

   subbytes_sched #(.MAX_KEY_STEAL(1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
   subbytes_sched #(.MAX_KEY_STEAL(0)) z_dut (.clk(clk), .rst_n(rst_n), .bus(z_if.slave));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   // Reference S-box: inverse found by exhaustive search, then the affine map bit by bit.
   logic [7:0] sb [256];

   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] c;
      logic [7:0] s;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sb[x] = s;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sb[w[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] sub_state(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[s[8*i +: 8]];
      return r;
   endfunction

   typedef struct {
      logic [127:0] data;
      int           t;
   } job_t;

   job_t st_q[$];
   job_t kw_q[$];
   int   cyc = 0;
   bit   mon_en = 1'b0;
   int   st_lat = 0, kw_lat = 0, st_pulses = 0, kw_pulses = 0;
   logic [127:0] st_last = '0;
   logic [31:0]  kw_last = '0;
   logic kw_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard for the MAX_KEY_STEAL=1 instance, sampled mid-cycle.
   always @(negedge clk) begin
      job_t j;
      if (!rst_n) begin
         st_q.delete();
         kw_q.delete();
      end else if (mon_en) begin
         chk("busy", 128'(u_if.busy), 128'((st_q.size() + kw_q.size()) != 0));
         if (u_if.st_out_valid === 1'b1) begin
            st_pulses++;
            st_last = u_if.st_out;
            if (st_q.size() == 0) chk("st_spurious", 128'(u_if.st_out_valid), 128'(0));
            else begin
               j = st_q.pop_front();
               st_lat = cyc - j.t;
               chk("st_out", u_if.st_out, j.data);
               chk("st_lat_bound", 128'(st_lat >= 5 && st_lat <= 9), 128'(1));
            end
         end
         if (u_if.kw_out_valid === 1'b1) begin
            kw_pulses++;
            kw_last = u_if.kw_out;
            chk("kw_single", 128'(kw_prev), 128'(0));
            if (kw_q.size() == 0) chk("kw_spurious", 128'(u_if.kw_out_valid), 128'(0));
            else begin
               j = kw_q.pop_front();
               kw_lat = cyc - j.t;
               chk("kw_out", 128'(u_if.kw_out), j.data);
               chk("kw_lat_bound", 128'(kw_lat >= 2 && kw_lat <= 3), 128'(1));
            end
         end
         if (u_if.st_valid && u_if.st_ready) begin
            j.data = sub_state(u_if.st_data);
            j.t = cyc;
            st_q.push_back(j);
         end
         if (u_if.kw_valid && u_if.kw_ready) begin
            j.data = 128'(sub_word(u_if.kw_data));
            j.t = cyc;
            kw_q.push_back(j);
         end
      end
      kw_prev <= u_if.kw_out_valid;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] sd;
      logic [31:0]  kd;
      int st_at, kw_at, p0, k0;

      rst_n = 1'b0;
      u_if.st_valid = 1'b0; u_if.st_data = '0; u_if.kw_valid = 1'b0; u_if.kw_data = '0;
      z_if.st_valid = 1'b0; z_if.st_data = '0; z_if.kw_valid = 1'b0; z_if.kw_data = '0;
      build_sbox();
      repeat (3) step();

      chk("rst_st_ready", 128'(u_if.st_ready), 128'(0));
      chk("rst_kw_ready", 128'(u_if.kw_ready), 128'(0));
      chk("rst_busy", 128'(u_if.busy), 128'(0));
      chk("rst_st_vld", 128'(u_if.st_out_valid), 128'(0));
      chk("rst_kw_vld", 128'(u_if.kw_out_valid), 128'(0));
      chk("rst_st_out", u_if.st_out, 128'(0));
      chk("rst_kw_out", 128'(u_if.kw_out), 128'(0));

      rst_n = 1'b1;
      step();
      mon_en = 1'b1;
      chk("rel_st_ready", 128'(u_if.st_ready), 128'(1));
      chk("rel_kw_ready", 128'(u_if.kw_ready), 128'(1));

      // Zero state, uncontended.
      k0 = kw_pulses; p0 = st_pulses;
      u_if.st_valid = 1'b1; u_if.st_data = 128'h0;
      step();
      u_if.st_valid = 1'b0;
      repeat (6) step();
      chk("t1_pulses", 128'(st_pulses - p0), 128'(1));
      chk("t1_lat", 128'(st_lat), 128'(5));
      chk("t1_out", st_last, {16{8'h63}});
      chk("t1_no_kw", 128'(kw_pulses - k0), 128'(0));

      // Single key, uncontended.
      u_if.kw_valid = 1'b1; u_if.kw_data = 32'h0001_0253;
      step();
      u_if.kw_valid = 1'b0;
      repeat (4) step();
      chk("t2_lat", 128'(kw_lat), 128'(2));
      chk("t2_out", 128'(kw_last), 128'(32'h637c_77ed));

      // Simultaneous state and key.
      u_if.st_valid = 1'b1; u_if.st_data = 128'h00112233445566778899aabbccddeeff;
      u_if.kw_valid = 1'b1; u_if.kw_data = 32'hffff_ffff;
      step();
      u_if.st_valid = 1'b0; u_if.kw_valid = 1'b0;
      repeat (8) step();
      chk("t3_kw_lat", 128'(kw_lat), 128'(2));
      chk("t3_kw_out", 128'(kw_last), 128'(32'h1616_1616));
      chk("t3_st_lat", 128'(st_lat), 128'(6));
      chk("t3_st_out", st_last, 128'h638293c31bfc33f5c4eeacea4bc12816);

      // Continuous keys against one state job: grants alternate.
      u_if.st_valid = 1'b1; u_if.st_data = {$urandom, $urandom, $urandom, $urandom};
      step();
      u_if.st_valid = 1'b0;
      u_if.kw_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         u_if.kw_data = $urandom;
         step();
      end
      u_if.kw_valid = 1'b0;
      repeat (4) step();
      chk("t4_st_lat", 128'(st_lat), 128'(8));

      // No stealing: key waits for the whole state job.
      chk("t5_st_ready", 128'(z_if.st_ready), 128'(1));
      sd = {$urandom, $urandom, $urandom, $urandom};
      kd = $urandom;
      z_if.st_valid = 1'b1; z_if.st_data = sd;
      step();
      z_if.st_valid = 1'b0;
      z_if.kw_valid = 1'b1; z_if.kw_data = kd;
      chk("t5_kw_ready", 128'(z_if.kw_ready), 128'(1));
      step();
      z_if.kw_valid = 1'b0;
      st_at = -1; kw_at = -1;
      for (int k = 2; k <= 9; k++) begin
         if (z_if.st_out_valid) begin st_at = k; chk("t5_st_out", z_if.st_out, sub_state(sd)); end
         if (z_if.kw_out_valid) begin kw_at = k; chk("t5_kw_out", 128'(z_if.kw_out), 128'(sub_word(kd))); end
         step();
      end
      chk("t5_st_at", 128'(st_at), 128'(5));
      chk("t5_kw_at", 128'(kw_at), 128'(6));

      // Reset in the middle of a state job.
      u_if.st_valid = 1'b1; u_if.st_data = {$urandom, $urandom, $urandom, $urandom};
      step();
      u_if.st_valid = 1'b0;
      step();
      p0 = st_pulses;
      rst_n = 1'b0;
      #1;
      chk("t6_ready_in_rst", 128'(u_if.st_ready), 128'(0));
      step();
      rst_n = 1'b1;
      #1;
      chk("t6_ready_after", 128'(u_if.st_ready), 128'(1));
      chk("t6_st_out", u_if.st_out, 128'(0));
      chk("t6_kw_out", 128'(u_if.kw_out), 128'(0));
      repeat (8) step();
      chk("t6_no_pulse", 128'(st_pulses - p0), 128'(0));

      // Random traffic against the scoreboard.
      for (int i = 0; i < 500; i++) begin
         u_if.st_valid = 1'($urandom_range(0, 1));
         u_if.st_data  = {$urandom, $urandom, $urandom, $urandom};
         u_if.kw_valid = ($urandom_range(0, 4) < 2);
         u_if.kw_data  = $urandom;
         step();
      end
      u_if.st_valid = 1'b0; u_if.kw_valid = 1'b0;
      repeat (12) step();
      chk("drain_st", 128'(st_q.size()), 128'(0));
      chk("drain_kw", 128'(kw_q.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/subbytes_sched.md
Name: subbytes_sched

Overview:
- Time-multiplexed SubBytes engine. Shares one 4-lane S-box bank (four `sbox` instances, 32 bits per cycle) between two requesters:
  - the round datapath, which needs a full 128-bit state substituted;
  - key expansion, which needs a 32-bit SubWord.
- Replaces the 16-instance parallel substitution where area matters.
- Sits between the round controller and key-schedule controller on one side and the ShiftRows stage on the other.

Parameters:
- MAX_KEY_STEAL, default 1: maximum consecutive key grants allowed while a state job is active. 0 means a key waits until the state job completes.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- st_valid  input  1  state job request.
- st_ready  output  1  state job slot free.
- st_data  input  128  state to substitute; word0 = [127:96], word3 = [31:0].
- st_out_valid  output  1  one-cycle pulse; st_out is valid.
- st_out  output  128  substituted state, same byte ordering as st_data.
- kw_valid  input  1  SubWord request.
- kw_ready  output  1  key slot free.
- kw_data  input  32  word to substitute.
- kw_out_valid  output  1  one-cycle pulse; kw_out is valid.
- kw_out  output  32  substituted word.
- busy  output  1  a state or key job is pending or in progress.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low; clock port is clk, reset port is rst_n.
- Reset values while rst_n=0: st_ready=0, kw_ready=0, st_out_valid=0, kw_out_valid=0, busy=0. st_out, kw_out, internal buffers, word counter and steal counter are all 0. The first cycle after release has st_ready=1 and kw_ready=1.
- Accept rules:
  - A state job is accepted on st_valid&&st_ready. st_data is captured into st_buf, word counter set to 0, st_active set.
  - st_ready = !st_active.
  - A key job is accepted on kw_valid&&kw_ready. kw_data is captured into kw_buf, kw_pend set.
  - kw_ready = !kw_pend.
  - Inputs are ignored when ready is low.
- Bank arbitration is evaluated every cycle on registered state only:
  - Key is granted if kw_pend && (!st_active || steal_cnt < MAX_KEY_STEAL).
  - Otherwise the state word is granted if st_active.
  - Otherwise the bank is idle and its input is 0.
- Key grant:
  - Bank input = kw_buf. Result is registered into kw_out; kw_out_valid=1 the next cycle; kw_pend cleared.
  - If st_active, steal_cnt increments, saturating at MAX_KEY_STEAL. The state word counter holds.
- State grant:
  - Bank input = st_buf word[cnt]. Result is written to st_acc word[cnt]; cnt increments; steal_cnt resets to 0.
  - On the cnt=3 grant: st_out is loaded with the full result, st_out_valid=1 the next cycle, st_active cleared, cnt wraps to 0.
- Latency, with acceptance at the edge ending cycle T:
  - Key, uncontended: bank cycle T+1, kw_out_valid at T+2.
  - State, uncontended: bank cycles T+1..T+4, st_out_valid at T+5.
  - Each key steal adds exactly one cycle to the state latency.
- Throughput:
  - st_ready reasserts in the st_out_valid cycle, so a new state job can be accepted then. Back-to-back jobs run at one per 5 cycles.
  - A new key can be accepted in the cycle after the key is granted.
- Simultaneous events:
  - Both requests accepted in the same cycle: key is granted first (steal_cnt=0 < 1), giving key out at T+2 and state out at T+6.
  - A key accepted in the same cycle a state grant occurs is granted next cycle, subject to the steal limit.
- No starvation:
  - With MAX_KEY_STEAL>=1, a state word is granted at least every MAX_KEY_STEAL+1 cycles.
  - The key is delayed by at most one state word, or at most the state-job remainder when MAX_KEY_STEAL=0.
- Outputs are registered. st_out and kw_out hold their last value between pulses.
- busy = st_active || kw_pend || st_out_valid || kw_out_valid.
- Reset mid-operation discards all jobs. No out_valid pulse is produced for discarded jobs.

Test Plan:
- Reset, then st_data=128'h0 accepted at T -> st_out_valid only at T+5, st_out=128'h6363...63; kw_out_valid stays 0.
- kw_data=32'h0001_0253 accepted at T with no state job -> kw_out_valid at T+2, kw_out=32'h637c_77ed.
- st_data=128'h00112233445566778899aabbccddeeff with kw_data=32'hffff_ffff accepted in the same cycle -> kw_out=32'h1616_1616 at T+2; st_out=128'h638293c31bfc33f5c4eeacea4bc12816 at T+6.
- MAX_KEY_STEAL=1, state accepted at T, keys presented continuously from T+1 -> key and state grants alternate; st_out_valid at T+8; each kw_out_valid is a single cycle.
- MAX_KEY_STEAL=0, state accepted at T, key accepted at T+1 -> state out at T+5, key bank cycle T+5, kw_out_valid at T+6.
- rst_n=0 for one cycle at T+2 of a state job -> no st_out_valid thereafter; st_ready=0 during reset and 1 the cycle after; st_out=0.
